// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package seq_divider_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/cla_sub_slice.sv
// 4-bit carry-lookahead subtract slice: d = a - b - bin, computed as a + ~b + ~bin.
module cla_sub_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       bin_i,
  output logic [3:0] d_o,
  output logic       bout_o
);
  logic [3:0] g, p;
  logic [4:0] c;

  // Carry-in of the adder form is the inverse of the incoming borrow.
  assign g    = a_i & ~b_i;
  assign p    = a_i ^ ~b_i;
  assign c[0] = ~bin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign d_o    = p ^ c[3:0];
  assign bout_o = ~c[4];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NSL = WIDTH / 4 + 1;
  localparam int PW  = 4 * NSL;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   s;
  logic [PW-1:0]    a_ext, b_ext, diff_ext;
  logic [NSL:0]     bc;
  logic             borrow;

  // Trial subtraction S - {0,D} over WIDTH+1 bits, zero-padded to whole slices.
  assign s     = {r_q, q_q[WIDTH-1]};
  assign a_ext = PW'(s);
  assign b_ext = PW'(d_q);
  assign bc[0] = 1'b0;

  for (genvar i = 0; i < NSL; i++) begin : g_slice
    cla_sub_slice u_slice (
      .a_i   (a_ext[4*i +: 4]),
      .b_i   (b_ext[4*i +: 4]),
      .bin_i (bc[i]),
      .d_o   (diff_ext[4*i +: 4]),
      .bout_o(bc[i+1])
    );
  end

  // Above bit WIDTH the operands are zero, so every padded result bit replicates the borrow.
  assign borrow = &{diff_ext[PW-1:WIDTH], bc[NSL]};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_RUN: begin
        r_d   = borrow ? s[WIDTH-1:0] : diff_ext[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          quo_d   = q_d;
          rem_d   = r_d;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = CW'(WIDTH - 1);
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d = ST_DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against plain-arithmetic division.
module tb_seq_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_assert = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one divide; inj>0 pulses a 9/2 start at that cycle of the run.
  task automatic run_div(input int a, input int b, input int inj,
                         output int q, output int r, output int z,
                         output int lat, output int busyc, output bit stable);
    logic [W-1:0] prevq, prevr;
    prevq = quotient;
    prevr = remainder;
    @(negedge clk);
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; busyc = 0; stable = 1'b1;
    while (!done && lat < 40) begin
      if (busy) begin
        busyc++;
        if (quotient !== prevq || remainder !== prevr) stable = 1'b0;
      end
      if (lat == inj) begin
        @(negedge clk);
        start = 1'b1; dividend = 8'd9; divisor = 8'd2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    q = int'(quotient); r = int'(remainder); z = int'(div_by_zero);
  endtask

  task automatic ref_check(input string tag, input int a, input int b, input int inj);
    int q, r, z, lat, busyc;
    bit stable;
    run_div(a, b, inj, q, r, z, lat, busyc, stable);
    if (b == 0) begin
      chk({tag, ".quo"}, q, (1 << W) - 1);
      chk({tag, ".rem"}, r, a);
      chk({tag, ".dbz"}, z, 1);
      chk({tag, ".lat"}, lat, 1);
      chk({tag, ".busy"}, busyc, 0);
    end else begin
      chk({tag, ".quo"}, q, a / b);
      chk({tag, ".rem"}, r, a % b);
      chk({tag, ".dbz"}, z, 0);
      chk({tag, ".lat"}, lat, W + 1);
      chk({tag, ".busy"}, busyc, W);
      chk({tag, ".stable"}, int'(stable), 1);
    end
  endtask

  initial begin
    int q, r, z, lat, busyc;
    bit stable, seen;
    int a, b;

    #12;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.quo", int'(quotient), 0);
    chk("rst.rem", int'(remainder), 0);
    chk("rst.dbz", int'(div_by_zero), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    ref_check("basic", 200, 7, 0);
    @(posedge clk); #1;
    ref_check("255/1", 255, 1, 0);
    ref_check("5/9", 5, 9, 0);
    ref_check("255/255", 255, 255, 0);
    @(posedge clk); #1;
    ref_check("dbz", 100, 0, 0);
    ref_check("after_dbz", 10, 3, 0);
    @(posedge clk); #1;

    // start pulsed mid-run is ignored
    ref_check("ignored", 200, 7, 3);
    @(posedge clk); #1;
    // back-to-back: the second start lands in the DONE cycle of the first
    ref_check("b2b.first", 200, 7, 0);
    ref_check("b2b.second", 9, 2, 0);
    @(posedge clk); #1;

    // asynchronous reset in the middle of a run
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    chk("midrst.quo", int'(quotient), 0);
    chk("midrst.rem", int'(remainder), 0);
    chk("midrst.dbz", int'(div_by_zero), 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("midrst.nodone", int'(seen), 0);
    ref_check("post_rst", 50, 6, 0);

    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(1, (1 << W) - 1));
      run_div(a, b, 0, q, r, z, lat, busyc, stable);
      chk("rnd.inv", q * b + r, a);
      chk("rnd.remlt", int'(r < b), 1);
      chk("rnd.lat", lat, W + 1);
      if (i % 7 == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
